fire_request_scheduler: RTL

FIRE_REQUEST_SCHEDULER -- requirements
Module: fire_request_scheduler

---
 rtl/fire_request_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fire_request_scheduler.sv
// Two-bay missile fire scheduler: round-robin console arbitration,
// bay balancing, post-launch cooldown and out-of-ammo lockout.
module fire_request_scheduler #(
  parameter int BAY_CAPACITY    = 4,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       target_locked,
  input  logic [3:0] fire_req,
  input  logic       reload,
  output logic [3:0] fire_grant,
  output logic       launch,
  output logic       launch_bay,
  output logic [2:0] bay0_count,
  output logic [2:0] bay1_count,
  output logic       busy,
  output logic [2:0] sched_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    ARBITRATE   = 3'b001,
    LAUNCH      = 3'b010,
    COOLDOWN    = 3'b011,
    OUT_OF_AMMO = 3'b100
  } state_t;

  localparam logic [2:0] CAP     = 3'(BAY_CAPACITY);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] grant_n;
  logic       launch_n, bay_n;
  logic [2:0] c0_n, c1_n;
  logic [1:0] last_grant, lg_n;
  logic       last_bay, lb_n;
  logic [7:0] cd, cd_n;
  logic [1:0] win, idx;
  logic       found, pick1, empty;

  assign empty = (bay0_count == 3'd0) && (bay1_count == 3'd0);
  assign busy = (state == ARBITRATE) || (state == LAUNCH) ||
                (state == COOLDOWN);
  assign sched_state = state;

  // Fuller bay wins; a tie alternates away from the last bay fired.
  assign pick1 = (bay1_count > bay0_count) ||
                 ((bay1_count == bay0_count) && !last_bay);

  always_comb begin
    win   = last_grant;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && fire_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fire_grant <= '0;
      launch     <= 1'b0;
      launch_bay <= 1'b0;
      bay0_count <= CAP;
      bay1_count <= CAP;
      last_grant <= 2'd3;
      last_bay   <= 1'b1;
      cd         <= '0;
    end else begin
      state      <= state_n;
      fire_grant <= grant_n;
      launch     <= launch_n;
      launch_bay <= bay_n;
      bay0_count <= c0_n;
      bay1_count <= c1_n;
      last_grant <= lg_n;
      last_bay   <= lb_n;
      cd         <= cd_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = '0;
    launch_n = 1'b0;
    bay_n    = launch_bay;
    c0_n     = bay0_count;
    c1_n     = bay1_count;
    lg_n     = last_grant;
    lb_n     = last_bay;
    cd_n     = cd;
    unique case (state)
      IDLE: begin
        if (reload) begin
          c0_n = CAP;
          c1_n = CAP;
        end else if (empty) begin
          state_n = OUT_OF_AMMO;
        end else if (target_locked && |fire_req) begin
          state_n = ARBITRATE;
        end
      end
      ARBITRATE: begin
        if (!target_locked || fire_req == 4'd0 || empty) begin
          state_n = IDLE;
        end else begin
          state_n  = LAUNCH;
          grant_n  = 4'b0001 << win;
          launch_n = 1'b1;
          bay_n    = pick1;
          lg_n     = win;
          lb_n     = pick1;
          if (pick1) c1_n = bay1_count - 3'd1;
          else       c0_n = bay0_count - 3'd1;
        end
      end
      LAUNCH: begin
        state_n = COOLDOWN;
        cd_n    = CD_LOAD;
      end
      COOLDOWN: begin
        if (cd == 8'd0) state_n = empty ? OUT_OF_AMMO : IDLE;
        else            cd_n = cd - 8'd1;
      end
      OUT_OF_AMMO: begin
        if (reload) begin
          c0_n    = CAP;
          c1_n    = CAP;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
